// File: rtl/tetris_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// tetris_pkg : command codes, game-state codes, priority helper
// Rev 1.0
// ------------------------------------------------------------------
package tetris_pkg;

  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_LEFT     = 3'd0;
  localparam cmd_t CMD_RIGHT    = 3'd1;
  localparam cmd_t CMD_ROTATE   = 3'd2;
  localparam cmd_t CMD_DROP     = 3'd3;
  localparam cmd_t CMD_HARDDROP = 3'd4;

  localparam logic [2:0] GS_START = 3'd0;
  localparam logic [2:0] GS_PLAY  = 3'd1;
  localparam logic [2:0] GS_CLEAR = 3'd2;
  localparam logic [2:0] GS_LOSE  = 3'd3;

  // Pending vector is indexed by command code.
  function automatic cmd_t pick_cmd(input logic [4:0] pend);
    if (pend[CMD_HARDDROP]) return CMD_HARDDROP;
    if (pend[CMD_ROTATE])   return CMD_ROTATE;
    if (pend[CMD_LEFT])     return CMD_LEFT;
    if (pend[CMD_RIGHT])    return CMD_RIGHT;
    return CMD_DROP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tetris_repeat_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// tetris_repeat_timer : held left/right auto-repeat, one-cycle fire pulse
// Rev 1.0
// ------------------------------------------------------------------
module tetris_repeat_timer #(
  parameter int CNT_W        = 26,
  parameter int REPEAT_DELAY = 15_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic left_i,
  input  logic right_i,
  output logic fire_o
);

  localparam logic [CNT_W-1:0] c_FIRE_AT = CNT_W'(REPEAT_DELAY - 1);
  // Reloading here makes the next fire land exactly REPEAT_RATE cycles later.
  localparam logic [CNT_W-1:0] c_RELOAD  = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held;

  assign held   = left_i ^ right_i;
  assign fire_o = held && (cnt_q == c_FIRE_AT);

  always_comb begin
    cnt_d = '0;
    if (held) begin
      cnt_d = fire_o ? c_RELOAD : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tetris_cmd_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tetris_cmd_scheduler : serialises button, auto-repeat and gravity events
// Rev 1.0
// ------------------------------------------------------------------
module tetris_cmd_scheduler
  import tetris_pkg::*;
#(
  parameter int CNT_W        = 26,
  parameter int DROP_PERIOD  = 50_000_000,
  parameter int FAST_PERIOD  = 5_000_000,
  parameter int REPEAT_DELAY = 15_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             move_left_i,
  input  logic             move_right_i,
  input  logic             rotate_i,
  input  logic             move_fast_i,
  input  logic             move_tobottom_i,
  input  logic             enable_i,
  input  logic             game_over_i,
  output logic             cmd_valid_o,
  output logic [2:0]       cmd_code_o,
  input  logic             cmd_ready_i,
  output logic [CNT_W-1:0] drop_count_o
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_OFFER = 2'd1;
  localparam logic [1:0] c_HALT  = 2'd2;

  localparam logic [CNT_W-1:0] c_DROP_LAST = CNT_W'(DROP_PERIOD - 1);
  localparam logic [CNT_W-1:0] c_FAST_LAST = CNT_W'(FAST_PERIOD - 1);

  logic [1:0]       state_q, state_d;
  logic [4:0]       pend_q, pend_d;
  logic [4:0]       btn_q, btn;
  cmd_t             code_q, code_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             rep_fire;
  logic [4:0]       set_vec, eff, clr;
  logic [CNT_W-1:0] p_last;
  logic             grav_run, grav_fire, lr_conflict, arb, xfer, hd_accept, halt_now;
  cmd_t             winner;

  // Button vector laid out by command code; the DROP slot has no button.
  assign btn = {move_tobottom_i, 1'b0, rotate_i, move_right_i, move_left_i};

  tetris_repeat_timer #(
    .CNT_W        (CNT_W),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_repeat (
    .clk     (clk),
    .rst     (rst),
    .left_i  (btn_q[CMD_LEFT]),
    .right_i (btn_q[CMD_RIGHT]),
    .fire_o  (rep_fire)
  );

  assign p_last      = move_fast_i ? c_FAST_LAST : c_DROP_LAST;
  assign grav_run    = enable_i && (state_q != c_HALT);
  assign grav_fire   = grav_run && (drop_cnt_q >= p_last);
  assign halt_now    = game_over_i || (state_q == c_HALT);
  assign xfer        = (state_q == c_OFFER) && cmd_ready_i;
  assign hd_accept   = xfer && (code_q == CMD_HARDDROP);
  assign arb         = (state_q == c_IDLE) && enable_i;
  assign lr_conflict = pend_q[CMD_LEFT] && pend_q[CMD_RIGHT];
  assign eff         = lr_conflict ? (pend_q & 5'b11100) : pend_q;
  assign winner      = pick_cmd(eff);

  always_comb begin
    set_vec = enable_i ? ((btn & ~btn_q)
                          | {3'b000, rep_fire & btn_q[CMD_RIGHT], rep_fire & btn_q[CMD_LEFT]})
                       : 5'b00000;
    set_vec = set_vec | {1'b0, grav_fire, 3'b000};

    clr = 5'b00000;
    if (arb) begin
      if (lr_conflict) clr = 5'b00011;
      if (|eff)        clr = clr | (5'b00001 << winner);
    end

    // Setting wins over consuming so an edge landing on the consume cycle survives.
    pend_d = (pend_q & ~clr) | set_vec;
    if (hd_accept) pend_d[CMD_DROP] = 1'b0;
    if (halt_now)  pend_d = 5'b00000;

    drop_cnt_d = drop_cnt_q;
    if (grav_run) drop_cnt_d = grav_fire ? '0 : drop_cnt_q + CNT_W'(1);
    if (hd_accept || halt_now) drop_cnt_d = '0;

    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      c_IDLE: begin
        if (arb && (|eff)) begin
          state_d = c_OFFER;
          code_d  = winner;
        end
      end
      c_OFFER: if (cmd_ready_i) state_d = c_IDLE;
      c_HALT:  if (!game_over_i) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
    if (game_over_i) state_d = c_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_IDLE;
      pend_q     <= '0;
      btn_q      <= '0;
      code_q     <= CMD_LEFT;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      btn_q      <= btn;
      code_q     <= code_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign cmd_valid_o  = (state_q == c_OFFER);
  assign cmd_code_o   = code_q;
  assign drop_count_o = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tetris_cmd_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_tetris_cmd_scheduler : vector table, directed corner cases, random run
// Rev 1.0
// ------------------------------------------------------------------
module tb_tetris_cmd_scheduler;

  localparam int CNT_W = 26;

  logic             clk = 1'b0;
  logic             rst;
  logic             move_left, move_right, rotate, move_fast, move_tobottom;
  logic             enable, game_over, cmd_ready;
  logic             cmd_valid;
  logic [2:0]       cmd_code;
  logic [CNT_W-1:0] drop_count;

  tetris_cmd_scheduler #(
    .CNT_W        (CNT_W),
    .DROP_PERIOD  (20),
    .FAST_PERIOD  (4),
    .REPEAT_DELAY (8),
    .REPEAT_RATE  (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .move_left_i     (move_left),
    .move_right_i    (move_right),
    .rotate_i        (rotate),
    .move_fast_i     (move_fast),
    .move_tobottom_i (move_tobottom),
    .enable_i        (enable),
    .game_over_i     (game_over),
    .cmd_valid_o     (cmd_valid),
    .cmd_code_o      (cmd_code),
    .cmd_ready_i     (cmd_ready),
    .drop_count_o    (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code;
    int         t;
  } xfer_t;

  typedef struct {
    logic       rot;
    logic       rdy;
    logic       exp_valid;
    logic [2:0] exp_code;
    int         exp_cnt;
  } vec_t;

  xfer_t xfers[$];
  int    cyc;
  int    n_cmp = 0;
  int    n_err = 0;

  // Cycle index = number of posedges since reset was released.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // A transfer happens at the next posedge when valid and ready are both high now.
  always @(negedge clk) begin
    if (!rst && cmd_valid === 1'b1 && cmd_ready === 1'b1)
      xfers.push_back('{code: cmd_code, t: cyc + 1});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_win(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected within [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Position so that the next step() lands on posedge k.
  task automatic goto(input int k);
    while (cyc < k - 1) step();
  endtask

  function automatic int count_code(input logic [2:0] c, input int t0, input int t1);
    int n = 0;
    foreach (xfers[i]) if (xfers[i].code == c && xfers[i].t >= t0 && xfers[i].t <= t1) n++;
    return n;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    {move_left, move_right, rotate, move_fast, move_tobottom, game_over} = '0;
    enable    = 1'b1;
    cmd_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_code",  32'(cmd_code), 0);
    check("rst_count", 32'(drop_count), 0);
    rst = 1'b0;
    xfers.delete();
  endtask

  vec_t tbl[1:26];

  initial begin
    int lt[$];
    int exp_t[6];
    int n_exp[5];
    int zeros;
    int next_press, hold_left, hold_btn;
    localparam int K_RAND = 610;

    // ---------------- table: single rotate, then a stalled gravity drop
    for (int k = 1; k <= 26; k++) begin
      tbl[k].rot       = (k == 10);
      tbl[k].rdy       = (k != 22);
      tbl[k].exp_valid = (k == 11 || k == 21 || k == 22);
      tbl[k].exp_code  = (k < 11) ? 3'd0 : (k < 21) ? 3'd2 : 3'd3;
      tbl[k].exp_cnt   = k % 20;
    end
    do_reset();
    for (int k = 1; k <= 26; k++) begin
      rotate    = tbl[k].rot;
      cmd_ready = tbl[k].rdy;
      step();
      check($sformatf("tbl_valid_k%0d", k), 32'(cmd_valid), 32'(tbl[k].exp_valid));
      check($sformatf("tbl_code_k%0d", k),  32'(cmd_code),  32'(tbl[k].exp_code));
      check($sformatf("tbl_count_k%0d", k), 32'(drop_count), 32'(tbl[k].exp_cnt));
    end
    check("tbl_rotate_xfers", 32'(count_code(3'd2, 1, 26)), 1);

    // ---------------- fast gravity from reset
    do_reset();
    move_fast = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("fast_count_k%0d", k), 32'(drop_count), 32'(k % 4));
    end
    check("fast_drop_xfers", 32'(count_code(3'd3, 1, 20)), 4);

    // ---------------- move_fast asserted mid-count fires on the next cycle
    do_reset();
    goto(11);
    check("mid_count_pre", 32'(drop_count), 10);
    move_fast = 1'b1;
    step();
    check("mid_count_wrap", 32'(drop_count), 0);
    move_fast = 1'b0;
    goto(16);
    step();
    check("mid_drop_xfer", 32'(count_code(3'd3, 12, 14)), 1);

    // ---------------- left held 20 cycles: edge command then auto-repeat
    do_reset();
    goto(3);
    move_left = 1'b1;
    for (int i = 0; i < 20; i++) step();
    move_left = 1'b0;
    goto(36);
    step();
    exp_t = '{5, 13, 16, 19, 22, 25};
    foreach (xfers[i]) if (xfers[i].code == 3'd0) lt.push_back(xfers[i].t);
    check("left_xfer_count", 32'(lt.size()), 6);
    for (int i = 0; i < 6 && i < lt.size(); i++)
      check_win($sformatf("left_xfer%0d_time", i), lt[i], exp_t[i], exp_t[i] + 2);

    // ---------------- simultaneous harddrop/rotate/left
    do_reset();
    goto(3);
    {rotate, move_left, move_tobottom} = 3'b111;
    step();
    {rotate, move_left, move_tobottom} = 3'b000;
    step();
    step();
    check("hd_count_zero", 32'(drop_count), 0);
    goto(10);
    step();
    check("order_n", 32'(xfers.size()), 3);
    if (xfers.size() >= 3) begin
      check("order_0", 32'(xfers[0].code), 4);
      check("order_1", 32'(xfers[1].code), 2);
      check("order_2", 32'(xfers[2].code), 0);
    end

    // ---------------- stalled ROTATE with three more rotate pulses
    do_reset();
    cmd_ready = 1'b0;
    goto(3);
    rotate = 1'b1; step(); rotate = 1'b0; step();
    for (int p = 0; p < 3; p++) begin
      rotate = 1'b1; step(); rotate = 1'b0; step();
      check($sformatf("stall_valid_%0d", p), 32'(cmd_valid), 1);
      check($sformatf("stall_code_%0d", p),  32'(cmd_code), 2);
    end
    goto(11);
    cmd_ready = 1'b1;
    goto(18);
    step();
    check("stall_rotate_total", 32'(count_code(3'd2, 1, 18)), 2);

    // ---------------- game_over in OFFER with a pending LEFT
    do_reset();
    cmd_ready = 1'b0;
    goto(3);
    rotate = 1'b1; step(); rotate = 1'b0;
    goto(5);
    move_left = 1'b1; step(); move_left = 1'b0;
    goto(7);
    game_over = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("halt_valid_%0d", i), 32'(cmd_valid), 0);
      check($sformatf("halt_count_%0d", i), 32'(drop_count), 0);
    end
    game_over = 1'b0;
    cmd_ready = 1'b1;
    goto(25);
    step();
    check("halt_no_left",   32'(count_code(3'd0, 1, 25)), 0);
    check("halt_no_rotate", 32'(count_code(3'd2, 1, 25)), 0);

    // ---------------- pause freezes gravity and ignores edges
    do_reset();
    goto(6);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rotate = (i == 1);
      step();
      check($sformatf("pause_count_%0d", i), 32'(drop_count), 5);
    end
    rotate = 1'b0;
    enable = 1'b1;
    step();
    check("resume_count", 32'(drop_count), 6);
    goto(20);
    step();
    check("pause_no_rotate", 32'(count_code(3'd2, 1, 20)), 0);

    // ---------------- reset in the middle of an offer drops it
    do_reset();
    cmd_ready = 1'b0;
    goto(3);
    rotate = 1'b1; step(); rotate = 1'b0;
    goto(6);
    check("pre_rst_valid", 32'(cmd_valid), 1);
    do_reset();
    goto(10);
    step();
    check("rst_lost_rotate", 32'(count_code(3'd2, 1, 10)), 0);

    // ---------------- random presses with random ready
    do_reset();
    n_exp      = '{default: 0};
    zeros      = 0;
    next_press = 5;
    hold_left  = 0;
    hold_btn   = 0;
    for (int k = 1; k <= K_RAND; k++) begin
      if (zeros >= 2) cmd_ready = 1'b1;
      else            cmd_ready = ($urandom_range(0, 9) < 7);
      zeros = cmd_ready ? 0 : zeros + 1;
      if (k == next_press) begin
        hold_btn  = $urandom_range(0, 2);
        hold_left = $urandom_range(1, 3);
        n_exp[hold_btn]++;
        next_press = k + 12 + $urandom_range(0, 8);
        if (next_press > K_RAND - 20) next_press = 0;
      end
      move_left  = (hold_left > 0) && (hold_btn == 0);
      move_right = (hold_left > 0) && (hold_btn == 1);
      rotate     = (hold_left > 0) && (hold_btn == 2);
      if (hold_left > 0) hold_left--;
      step();
      check($sformatf("rnd_count_k%0d", k), 32'(drop_count), 32'(k % 20));
    end
    check("rnd_left",   32'(count_code(3'd0, 1, K_RAND)), 32'(n_exp[0]));
    check("rnd_right",  32'(count_code(3'd1, 1, K_RAND)), 32'(n_exp[1]));
    check("rnd_rotate", 32'(count_code(3'd2, 1, K_RAND)), 32'(n_exp[2]));
    check("rnd_drop",   32'(count_code(3'd3, 1, K_RAND)), 32'(K_RAND / 20));
    check("rnd_hard",   32'(count_code(3'd4, 1, K_RAND)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tetris_cmd_scheduler.md
Name: tetris_cmd_scheduler

Overview:
Sits between the debounced player buttons and the Tetris game FSM (Tetris_design). It turns button edges, held-button auto-repeat and an internal gravity timer into a single serialized stream of move commands. Commands are offered to the game FSM over a valid/ready handshake. This removes per-button timing from the game FSM and guarantees one piece action per accepted transfer.

Parameters:
CNT_W, 26, width of the gravity and repeat counters
DROP_PERIOD, 50_000_000, cycles between gravity drops in normal speed
FAST_PERIOD, 5_000_000, cycles between gravity drops while move_fast is held
REPEAT_DELAY, 15_000_000, cycles a left/right button must be held before auto-repeat starts
REPEAT_RATE, 5_000_000, cycles between auto-repeat commands

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
move_left  in  1  level, debounced
move_right  in  1  level, debounced
rotate  in  1  level, debounced
move_fast  in  1  level; selects FAST_PERIOD
move_tobottom  in  1  level, debounced
enable  in  1  0 = pause; gravity counter frozen, button edges ignored
game_over  in  1  game FSM is in LOSE state
cmd_valid  out  1  command offered
cmd_code  out  3  CMD_LEFT=0, CMD_RIGHT=1, CMD_ROTATE=2, CMD_DROP=3, CMD_HARDDROP=4
cmd_ready  in  1  game FSM accepts cmd_code this cycle
drop_count  out  CNT_W  current gravity counter value (debug)

Behaviour:
- Reset (rst=1 at posedge): cmd_valid=0, cmd_code=0, drop_count=0, all pending bits=0, button history regs=0, repeat counter=0, state=IDLE.
- Edge detect: each button is registered once; edge = btn & ~btn_q. An edge sets that command's pending bit on the next posedge.
- Repeated edges while a command is already pending collapse into that one pending bit. The pending bit is not a counter.
- An edge in the same cycle its pending bit is consumed leaves the bit set, so the new event is not lost.
- Left and right pending simultaneously at arbitration: both are cleared and neither is issued.
- Auto-repeat:
  - While exactly one of move_left/move_right is held, the repeat counter counts up.
  - At REPEAT_DELAY-1 the held direction's pending bit is set and the counter reloads so that the next fire comes REPEAT_RATE cycles later. Subsequent fires repeat every REPEAT_RATE cycles.
  - Release, or both directions held, clears the counter.
- Gravity:
  - drop_count increments every cycle while enable=1 and state!=HALT.
  - Period P = move_fast ? FAST_PERIOD : DROP_PERIOD.
  - When drop_count >= P-1, drop pending is set and drop_count returns to 0. This covers move_fast being asserted mid-count: the drop fires on the next cycle.
- Arbitration, fixed priority: HARDDROP > ROTATE > LEFT > RIGHT > DROP.
- FSM states:
  - IDLE: cmd_valid=0. If any pending bit is set, latch the winner into cmd_code, clear its pending bit, and go to OFFER. cmd_valid=1 on the following cycle.
  - OFFER: cmd_valid=1, and cmd_code is held stable until cmd_ready=1. Then go to IDLE. Back-to-back offers are separated by one IDLE cycle.
  - HALT: entered from any state when game_over=1. Clears all pending bits, cmd_valid=0, drop_count=0. Exits to IDLE when game_over=0.
- HARDDROP acceptance clears drop pending and resets drop_count to 0.
- enable=0 in OFFER: the offer is held; the handshake still completes.
- Latency: a button edge at posedge N yields cmd_valid=1 at N+2, with ready held high.
- rst mid-OFFER drops the offer immediately; the command is lost by design.

Decomposition:
- Shared package tetris_pkg: CMD_* codes, cmd_t typedef, and the existing game-state codes (LOSE etc.).
- One sub-module, tetris_repeat_timer, holds the held-button auto-repeat counter (parameters REPEAT_DELAY, REPEAT_RATE). Its output is a one-cycle fire pulse.

Test Plan:
(Parameter overrides for all tests: DROP_PERIOD=20, FAST_PERIOD=4, REPEAT_DELAY=8, REPEAT_RATE=3; cmd_ready=1 unless stated.)
1. rotate held high for 1 cycle at posedge 10 -> cmd_valid=1, cmd_code=2 at posedge 12, exactly one transfer.
2. No buttons pressed for 60 cycles -> CMD_DROP transfers at cycles 20, 40 and 60 ±2. move_fast=1 from cycle 65 -> drops every 4 cycles.
3. move_left held 20 cycles -> CMD_LEFT transfers once from the edge, then at hold-cycles 8, 11, 14, 17, 20 (±2 latency).
4. rotate, move_left and move_tobottom all rise in the same cycle -> order HARDDROP, ROTATE, LEFT. drop_count reads 0 after the HARDDROP transfer.
5. cmd_ready=0 for 10 cycles with ROTATE offered and rotate pulsed 3 more times -> cmd_code stays 2. After ready rises: exactly 2 ROTATE transfers total.
6. game_over=1 while in OFFER with pending LEFT -> cmd_valid=0 the next cycle and drop_count=0. After game_over=0: no stale LEFT is issued.
